demux_rr_scheduler: RTL and testbench
=====================================

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter: DATA_W, 8, width of each routed data word.
REQ-002 Parameter: NUM_CH, 16, number of output channels; SHALL be fixed at 16, with SEL_W = 4.
REQ-003 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream word present.
REQ-006 Port: in_data  input  DATA_W  upstream word.
REQ-007 Port: in_ready  output  1  block accepts the word this cycle.
REQ-008 Port: ch_en  input  16  per-channel enable mask.
REQ-009 Port: ch_ready  input  16  per-channel sink ready.
REQ-010 Port: sel  output  4  index of the currently granted channel.
REQ-011 Port: out_valid  output  16  one-hot valid, set only at bit sel.
REQ-012 Port: out_data  output  DATA_W  held word, broadcast to all channels.
REQ-013 Port: busy  output  1  high while a word is held.
REQ-014 Port: sent_cnt  output  16  count of delivered words.
REQ-015 Port: drop_cnt  output  16  count of dropped words.

Function
REQ-016 FSM states SHALL be IDLE (no word held) and HOLD (word held on sel); busy SHALL equal (state==HOLD).
REQ-017 Round-robin search SHALL start at ptr+1 and wrap mod 16; the target SHALL be the first channel with ch_en set.
REQ-018 in_ready SHALL be 1 only when an enabled target exists AND (state==IDLE OR (state==HOLD AND ch_ready[sel])).
REQ-019 On accept (in_valid & in_ready), the block SHALL register in_data into out_data, sel into target, ptr into target, and enter or stay in HOLD; latency from accept to out_valid SHALL be 1 cycle.
REQ-020 In HOLD, out_valid SHALL equal 16'b1 << sel; out_data and sel SHALL be stable until delivery.
REQ-021 Delivery occurs when ch_ready[sel] is high in HOLD; sent_cnt SHALL increment by 1, and the FSM SHALL go to IDLE unless a new word is accepted in the same cycle (back-to-back, no bubble).
REQ-022 If ch_en[sel] is low in HOLD and ch_ready[sel] is low, the word SHALL be dropped: drop_cnt SHALL increment, the FSM SHALL go to IDLE, and in_ready SHALL be 0 that cycle.
REQ-023 If ch_en is all zero, in_ready SHALL be 0; a held word SHALL follow REQ-021/REQ-022.
REQ-024 ptr SHALL advance only on accept, never on delivery or drop.
REQ-025 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-026 On rst: state=IDLE, ptr=15, sel=0, out_valid=0, out_data=0, busy=0, sent_cnt=0, drop_cnt=0; in_ready SHALL follow REQ-018 from these values.
REQ-027 Reset asserted mid-HOLD SHALL discard the held word without counting it.

Configuration
REQ-028 With DEMUX_RR_STATS_EN defined, sent_cnt and drop_cnt SHALL behave per REQ-021, REQ-022 and REQ-025.
REQ-029 Without DEMUX_RR_STATS_EN, the counter registers SHALL be absent; both ports SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-030 A shared package demux_rr_pkg SHALL hold NUM_CH, SEL_W and the state enum (IDLE, HOLD).
REQ-031 The one-hot out_valid decode SHALL be a sub-module instance of demux_4_to_16, with sel driven from sel and in driven from (state==HOLD).
REQ-032 The round-robin search SHALL be a combinational function in the package.

Verification
REQ-033 Reset, then ch_en=16'hFFFF, ch_ready=16'hFFFF, 4 words -> sel 0,1,2,3 in successive cycles; sent_cnt=4; in_ready stays 1 throughout.
REQ-034 ch_en=16'h8001, ptr=15, 3 words -> sel 0,15,0 (wrap-around).
REQ-035 Grant ch 5 with ch_ready[5]=0 for 3 cycles -> out_valid=16'h0020 and out_data stable, in_ready=0; on ch_ready[5]=1, delivery occurs with the next word accepted in the same cycle.
REQ-036 HOLD on ch 7, ch_en[7] cleared with ch_ready[7]=0 -> drop_cnt=1, IDLE next cycle, out_valid=0.
REQ-037 ch_en=0 with in_valid=1 -> in_ready=0 indefinitely; rst pulsed mid-HOLD -> all outputs at reset values asynchronously.
REQ-038 Build without DEMUX_RR_STATS_EN and rerun REQ-033 -> identical routing, sent_cnt=0.

Source files
------------

// File: rtl/demux_rr_pkg.sv
// Shared constants, FSM state type and round-robin search for demux_rr_scheduler.
package demux_rr_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First enabled channel at ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
  function automatic rr_pick_t rr_search(input logic [SEL_W-1:0]  ptr,
                                         input logic [NUM_CH-1:0] en);
    rr_pick_t         pick;
    logic [SEL_W-1:0] idx;
    pick = '0;
    // Walk from the farthest offset down so the nearest enabled channel wins.
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (en[idx]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_4_to_16.sv
// 4-to-16 one-hot decoder with enable; drives the per-channel valid lines.
module demux_4_to_16 (
  input  logic [3:0]  sel,
  input  logic        in,
  output logic [15:0] out
);

  always_comb begin
    out = '0;
    if (in) begin
      out[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin demultiplexer: holds one word and routes it to the next enabled channel.
// Define DEMUX_RR_STATS_EN to build the saturating sent/drop counters; otherwise they read 0.
module demux_rr_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [3:0]        sel,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       sent_cnt,
  output logic [15:0]       drop_cnt
);

  import demux_rr_pkg::*;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, sel_q;
  logic [DATA_W-1:0] data_q;
  rr_pick_t          pick;
  logic              accept, deliver, drop;

  always_comb begin
    pick     = rr_search(ptr_q, ch_en);
    deliver  = (state_q == HOLD) && ch_ready[sel_q];
    // A channel that is neither enabled nor ready loses its word.
    drop     = (state_q == HOLD) && !ch_ready[sel_q] && !ch_en[sel_q];
    in_ready = pick.found && ((state_q == IDLE) || deliver);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = HOLD;
    end else if (deliver || drop) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= pick.idx;
        sel_q  <= pick.idx;
        data_q <= in_data;
      end
    end
  end

  demux_4_to_16 u_valid_dec (
    .sel (sel_q),
    .in  (state_q == HOLD),
    .out (out_valid)
  );

  assign sel      = sel_q;
  assign out_data = data_q;
  assign busy     = (state_q == HOLD);

`ifdef DEMUX_RR_STATS_EN
  logic [15:0] sent_q, drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      if (deliver && (sent_q != 16'hFFFF)) begin
        sent_q <= sent_q + 16'd1;
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign sent_cnt = sent_q;
  assign drop_cnt = drop_q;
`else
  assign sent_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: cycle model plus expected-delivery scoreboard.
module tb_demux_rr_scheduler;

`ifdef DEMUX_RR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] ch_en, ch_ready;
  logic [3:0]  sel;
  logic [15:0] out_valid;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] sent_cnt, drop_cnt;

  demux_rr_scheduler #(
    .DATA_W (8),
    .NUM_CH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .ch_ready  (ch_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .sent_cnt  (sent_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit          m_hold;
  logic [3:0]  m_ptr, m_sel;
  logic [7:0]  m_data;
  int          m_sent, m_drop;

  // Expected deliveries/drops in order: {channel, data}
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 4'd15;
    m_sel  = 4'd0;
    m_data = 8'd0;
    m_sent = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input logic vld, input logic [7:0] data,
                     input logic [15:0] en, input logic [15:0] rdy);
    bit         found, exp_rdy, acc, dlv, drp;
    logic [3:0] tgt, idx;
    logic [11:0] item;
    in_valid = vld;
    in_data  = data;
    ch_en    = en;
    ch_ready = rdy;
    @(negedge clk);
    found = 1'b0;
    tgt   = 4'd0;
    for (int i = 1; i <= 16 && !found; i++) begin
      idx = 4'((int'(m_ptr) + i) % 16);
      if (en[idx]) begin
        found = 1'b1;
        tgt   = idx;
      end
    end
    dlv     = m_hold && rdy[m_sel];
    drp     = m_hold && !rdy[m_sel] && !en[m_sel];
    exp_rdy = found && (!m_hold || dlv);
    acc     = vld && exp_rdy;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_hold));
    check("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_sel) : 32'd0);
    if (m_hold) begin
      check("sel", 32'(sel), 32'(m_sel));
      check("out_data", 32'(out_data), 32'(m_data));
    end
    check("sent_cnt", 32'(sent_cnt), STATS ? 32'(m_sent) : 32'd0);
    check("drop_cnt", 32'(drop_cnt), STATS ? 32'(m_drop) : 32'd0);
    if (dlv || drp) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        item = exp_q.pop_front();
        check(drp ? "sb_drop_sel" : "sb_sel", 32'(sel), 32'(item[11:8]));
        check(drp ? "sb_drop_data" : "sb_data", 32'(out_data), 32'(item[7:0]));
      end
    end
    @(posedge clk);
    #1;
    if (dlv && m_sent < 65535) m_sent++;
    if (drp && m_drop < 65535) m_drop++;
    if (acc) begin
      m_hold = 1'b1;
      m_ptr  = tgt;
      m_sel  = tgt;
      m_data = data;
    end else if (dlv || drp) begin
      m_hold = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ch_en    = '0;
    ch_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 8'h00, 16'h0000, 16'h0000);
    cyc(1'b0, 8'h00, 16'hFFFF, 16'hFFFF);

    // All channels open: four back-to-back words go to 0,1,2,3.
    exp_q.push_back({4'd0, 8'hA0});
    exp_q.push_back({4'd1, 8'hA1});
    exp_q.push_back({4'd2, 8'hA2});
    exp_q.push_back({4'd3, 8'hA3});
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 16'hFFFF, 16'hFFFF);
    cyc(1'b0, 8'h00, 16'hFFFF, 16'hFFFF);
    check("sent_after_four", 32'(sent_cnt), STATS ? 32'd4 : 32'd0);
    check("ptr_after_four", 32'(sel), 32'd3);

    // Wrap-around between channels 0 and 15 from a fresh pointer.
    pulse_reset();
    exp_q.push_back({4'd0, 8'h10});
    exp_q.push_back({4'd15, 8'h11});
    exp_q.push_back({4'd0, 8'h12});
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h10 + 8'(i), 16'h8001, 16'hFFFF);
    cyc(1'b0, 8'h00, 16'h8001, 16'hFFFF);

    // Channel 5 stalls three cycles, then delivers with the next word accepted same cycle.
    exp_q.push_back({4'd5, 8'hB0});
    exp_q.push_back({4'd5, 8'hB1});
    cyc(1'b1, 8'hB0, 16'h0020, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hB1, 16'h0020, 16'h0000);
    check("stall_out_valid", 32'(out_valid), 32'h0020);
    cyc(1'b1, 8'hB1, 16'h0020, 16'h0020);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_data", 32'(out_data), 32'hB1);
    cyc(1'b0, 8'h00, 16'h0020, 16'h0020);

    // Channel 7 disabled while holding and not ready: word dropped.
    exp_q.push_back({4'd7, 8'hC0});
    cyc(1'b1, 8'hC0, 16'h0080, 16'h0000);
    cyc(1'b1, 8'hC1, 16'h0000, 16'h0000);
    cyc(1'b0, 8'h00, 16'h0000, 16'h0000);
    check("drop_out_valid", 32'(out_valid), 32'd0);
    check("drop_cnt_one", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);

    // Nothing enabled: never ready.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hD0, 16'h0000, 16'hFFFF);

    // Reset in the middle of a hold discards the word.
    cyc(1'b1, 8'hE0, 16'hFFFF, 16'h0000);
    cyc(1'b0, 8'h00, 16'hFFFF, 16'h0000);
    pulse_reset();
    cyc(1'b0, 8'h00, 16'hFFFF, 16'hFFFF);
    exp_q.push_back({4'd0, 8'hE1});
    cyc(1'b1, 8'hE1, 16'hFFFF, 16'hFFFF);
    cyc(1'b0, 8'h00, 16'hFFFF, 16'hFFFF);
    check("final_sent", 32'(sent_cnt), STATS ? 32'd1 : 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
